// File: rtl/decode_exec_writeback_pkg.sv
// Shared encodings for the single-cycle RV32I decode/execute/writeback slice.
package decode_exec_writeback_pkg;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3SrlSra = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;
    localparam logic [2:0] F3Word   = 3'b010;
    localparam logic [2:0] F3Jalr   = 3'b000;
    localparam logic [2:0] F3Beq    = 3'b000;
    localparam logic [2:0] F3Bne    = 3'b001;
    localparam logic [2:0] F3Blt    = 3'b100;
    localparam logic [2:0] F3Bge    = 3'b101;
    localparam logic [2:0] F3Bltu   = 3'b110;
    localparam logic [2:0] F3Bgeu   = 3'b111;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    localparam logic [31:0] EbreakInst = 32'h0010_0073;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluAnd   = 4'd2,
        AluOr    = 4'd3,
        AluXor   = 4'd4,
        AluSlt   = 4'd5,
        AluSltu  = 4'd6,
        AluEq    = 4'd7,
        AluNe    = 4'd8,
        AluGe    = 4'd9,
        AluGeu   = 4'd10,
        AluSll   = 4'd11,
        AluSrl   = 4'd12,
        AluSra   = 4'd13,
        AluPassB = 4'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        WbAlu = 2'd0,
        WbMem = 2'd1,
        WbPc4 = 2'd2
    } wb_sel_e;

    typedef enum logic {
        Src2Reg = 1'b0,
        Src2Imm = 1'b1
    } src2_sel_e;

endpackage

// File: rtl/dew_alu.sv
// Combinational ALU; compare ops yield 0/1 zero-extended, shifts use src2[4:0].
module dew_alu
    import decode_exec_writeback_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] res
);

    logic [4:0] shamt;

    assign shamt = src2[4:0];

    always_comb begin
        res = '0;
        case (alu_op_e'(op))
            AluAdd:   res = src1 + src2;
            AluSub:   res = src1 - src2;
            AluAnd:   res = src1 & src2;
            AluOr:    res = src1 | src2;
            AluXor:   res = src1 ^ src2;
            AluSlt:   res = XLEN'($signed(src1) < $signed(src2));
            AluSltu:  res = XLEN'(src1 < src2);
            AluEq:    res = XLEN'(src1 == src2);
            AluNe:    res = XLEN'(src1 != src2);
            AluGe:    res = XLEN'($signed(src1) >= $signed(src2));
            AluGeu:   res = XLEN'(src1 >= src2);
            AluSll:   res = src1 << shamt;
            AluSrl:   res = src1 >> shamt;
            AluSra:   res = $unsigned($signed(src1) >>> shamt);
            AluPassB: res = src2;
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/decode_exec_writeback.sv
// Single-cycle RV32I slice: decode, GPR read, ALU and clocked register writeback.
module decode_exec_writeback
    import decode_exec_writeback_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           inst,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       lw_data,
    output logic [4:0]            rd,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [XLEN-1:0]       imm,
    output logic [XLEN-1:0]       rs1_val,
    output logic [XLEN-1:0]       sw_data,
    output logic [XLEN-1:0]       alu_res,
    output logic                  sig_mem_we,
    output logic                  sig_fetch_advance_gpr,
    output logic                  sig_fetch_advance_by_imm,
    output logic                  sig_fetch_bcond,
    output logic                  sig_ebreak,
    output logic                  sig_illegal,
    output logic [XLEN*NREGS-1:0] gpr
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    alu_op_e   alu_op;
    src2_sel_e src2_sel;
    wb_sel_e   wb_sel;
    logic      wb_en;
    logic      mem_we, adv_gpr, adv_imm, bcond, ebreak, illegal;

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] src2, wb_val;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        alu_op   = AluAdd;
        src2_sel = Src2Imm;
        wb_sel   = WbAlu;
        wb_en    = 1'b0;
        mem_we   = 1'b0;
        adv_gpr  = 1'b0;
        adv_imm  = 1'b0;
        bcond    = 1'b0;
        ebreak   = 1'b0;
        illegal  = 1'b0;
        imm      = imm_i;
        case (opcode)
            OpcOp: begin
                src2_sel = Src2Reg;
                wb_en    = 1'b1;
                unique case (funct3)
                    F3AddSub: alu_op = funct7[5] ? AluSub : AluAdd;
                    F3Sll:    alu_op = AluSll;
                    F3Slt:    alu_op = AluSlt;
                    F3Sltu:   alu_op = AluSltu;
                    F3Xor:    alu_op = AluXor;
                    F3SrlSra: alu_op = funct7[5] ? AluSra : AluSrl;
                    F3Or:     alu_op = AluOr;
                    F3And:    alu_op = AluAnd;
                endcase
                // Only SUB and SRA may carry the alternate funct7.
                if (!(funct7 == F7Zero ||
                      (funct7 == F7Alt && (funct3 == F3AddSub || funct3 == F3SrlSra)))) begin
                    illegal = 1'b1;
                end
            end
            OpcOpImm: begin
                wb_en = 1'b1;
                unique case (funct3)
                    F3AddSub: alu_op = AluAdd;
                    F3Sll:    alu_op = AluSll;
                    F3Slt:    alu_op = AluSlt;
                    F3Sltu:   alu_op = AluSltu;
                    F3Xor:    alu_op = AluXor;
                    F3SrlSra: alu_op = funct7[5] ? AluSra : AluSrl;
                    F3Or:     alu_op = AluOr;
                    F3And:    alu_op = AluAnd;
                endcase
                if ((funct3 == F3Sll && funct7 != F7Zero) ||
                    (funct3 == F3SrlSra && funct7 != F7Zero && funct7 != F7Alt)) begin
                    illegal = 1'b1;
                end
            end
            OpcLoad: begin
                wb_sel  = WbMem;
                wb_en   = 1'b1;
                illegal = (funct3 != F3Word);
            end
            OpcStore: begin
                imm     = imm_s;
                mem_we  = 1'b1;
                illegal = (funct3 != F3Word);
            end
            OpcLui: begin
                imm    = imm_u;
                alu_op = AluPassB;
                wb_en  = 1'b1;
            end
            OpcJal: begin
                imm     = imm_j;
                wb_sel  = WbPc4;
                wb_en   = 1'b1;
                adv_imm = 1'b1;
            end
            OpcJalr: begin
                wb_sel  = WbPc4;
                wb_en   = 1'b1;
                adv_gpr = 1'b1;
                illegal = (funct3 != F3Jalr);
            end
            OpcBranch: begin
                imm      = imm_b;
                src2_sel = Src2Reg;
                bcond    = 1'b1;
                case (funct3)
                    F3Beq:   alu_op = AluEq;
                    F3Bne:   alu_op = AluNe;
                    F3Blt:   alu_op = AluSlt;
                    F3Bge:   alu_op = AluGe;
                    F3Bltu:  alu_op = AluSltu;
                    F3Bgeu:  alu_op = AluGeu;
                    default: illegal = 1'b1;
                endcase
            end
            OpcSystem: begin
                if (inst == EbreakInst) ebreak = 1'b1;
                else                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal || ebreak) begin
            wb_en   = 1'b0;
            mem_we  = 1'b0;
            adv_gpr = 1'b0;
            adv_imm = 1'b0;
            bcond   = 1'b0;
        end
    end

    assign sig_mem_we               = mem_we;
    assign sig_fetch_advance_gpr    = adv_gpr;
    assign sig_fetch_advance_by_imm = adv_imm;
    assign sig_fetch_bcond          = bcond;
    assign sig_ebreak               = ebreak;
    assign sig_illegal              = illegal;

    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign sw_data = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign src2    = (src2_sel == Src2Reg) ? sw_data : imm;

    dew_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .src1 (rs1_val),
        .src2 (src2),
        .op   (alu_op),
        .res  (alu_res)
    );

    always_comb begin
        case (wb_sel)
            WbMem:   wb_val = lw_data;
            WbPc4:   wb_val = pc + XLEN'(4);
            default: wb_val = alu_res;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_en && rd != 5'd0) begin
            regs[rd] <= wb_val;
        end
    end

    always_comb begin
        gpr = '0;
        for (int i = 1; i < NREGS; i++) gpr[XLEN*i +: XLEN] = regs[i];
    end

endmodule

// File: tb/tb_decode_exec_writeback.sv
// Directed plus randomized bench for decode_exec_writeback against a mnemonic-level model.
module tb_decode_exec_writeback;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_JR  = 7'b1100111;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   inst, pc, lw_data;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   imm, rs1_val, sw_data, alu_res;
    logic          sig_mem_we, sig_fetch_advance_gpr, sig_fetch_advance_by_imm;
    logic          sig_fetch_bcond, sig_ebreak, sig_illegal;
    logic [1023:0] gpr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m [32];

    // Mnemonic order: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU
    int r_f3 [10] = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3};
    // ADDI ANDI ORI XORI SLTI SLTIU SLLI SRLI SRAI -> mnemonic index and funct3
    int i_op [9] = '{0, 2, 3, 4, 8, 9, 5, 6, 7};
    int i_f3 [9] = '{0, 7, 6, 4, 2, 3, 1, 5, 5};
    // BEQ BNE BLT BGE BLTU BGEU
    int b_f3 [6] = '{0, 1, 4, 5, 6, 7};

    always #5 clk = ~clk;

    decode_exec_writeback dut (
        .clk                      (clk),
        .reset                    (reset),
        .inst                     (inst),
        .pc                       (pc),
        .lw_data                  (lw_data),
        .rd                       (rd),
        .rs1                      (rs1),
        .rs2                      (rs2),
        .imm                      (imm),
        .rs1_val                  (rs1_val),
        .sw_data                  (sw_data),
        .alu_res                  (alu_res),
        .sig_mem_we               (sig_mem_we),
        .sig_fetch_advance_gpr    (sig_fetch_advance_gpr),
        .sig_fetch_advance_by_imm (sig_fetch_advance_by_imm),
        .sig_fetch_bcond          (sig_fetch_bcond),
        .sig_ebreak               (sig_ebreak),
        .sig_illegal              (sig_illegal),
        .gpr                      (gpr)
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {f7, s2, s1, f3, d, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d,
                                          input logic [6:0] opc);
        return {im, s1, f3, d, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] s2,
                                          input logic [4:0] s1);
        return {im[11:5], s2, s1, 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3);
        return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] d);
        return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] up, input logic [4:0] d);
        return {up, d, 7'b0110111};
    endfunction

    function automatic logic [31:0] ref_op(input int op, input logic [31:0] a,
                                           input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            5:       return a << sh;
            6:       return a >> sh;
            7:       return $unsigned($signed(a) >>> sh);
            8:       return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return (a < b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input int k, input logic [31:0] a, input logic [31:0] b);
        case (k)
            0:       return a == b;
            1:       return a != b;
            2:       return $signed(a) < $signed(b);
            3:       return $signed(a) >= $signed(b);
            4:       return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic logic [1023:0] model_flat();
        logic [1023:0] f;
        f = '0;
        for (int i = 1; i < 32; i++) f[32*i +: 32] = m[i];
        return f;
    endfunction

    function automatic logic [31:0] reg_of(input int i);
        return gpr[32*i +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_file(input string tag);
        logic [1023:0] exp;
        exp = model_flat();
        n_checks++;
        assert (gpr === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, gpr, exp);
        end
    endtask

    task automatic set(input logic [31:0] i);
        inst = i;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a, b, exp, ins, ld;
        logic [11:0] im12;
        logic [4:0]  d, s1, s2;
        int          k, sel;

        reset = 1'b1;
        inst = 32'h0;
        pc = 32'h0;
        lw_data = 32'h0;
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        tick();
        reset = 1'b0;
        chk_file("reset_file");

        set(enc_i(12'd5, 5'd0, 3'd0, 5'd1, OP_I)); tick(); m[1] = 32'd5;
        chk("addi_x1", reg_of(1), 32'd5);
        set(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, OP_I)); tick(); m[2] = 32'hFFFF_FFFD;
        chk("addi_x2", reg_of(2), 32'hFFFF_FFFD);
        set(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3)); tick(); m[3] = 32'd2;
        chk("add_x3", reg_of(3), 32'd2);
        set(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4)); tick(); m[4] = 32'hFFFF_FFF8;
        chk("sub_x4", reg_of(4), 32'hFFFF_FFF8);

        set(enc_i(12'd7, 5'd0, 3'd0, 5'd0, OP_I));
        chk("x0_alu", alu_res, 32'd7);
        tick();
        chk("x0_field", gpr[31:0], 32'h0);
        chk_file("x0_file");

        reset = 1'b1;
        set(enc_i(12'd9, 5'd0, 3'd0, 5'd1, OP_I)); tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        chk_file("reset_wins");

        set(enc_i(12'h100, 5'd0, 3'd0, 5'd1, OP_I)); tick(); m[1] = 32'h100;
        set(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, OP_I)); tick(); m[2] = 32'hFFFF_FFFD;
        set(enc_s(12'd8, 5'd2, 5'd1));
        chk("sw_we", 32'(sig_mem_we), 32'd1);
        chk("sw_addr", alu_res, 32'h108);
        chk("sw_data", sw_data, 32'hFFFF_FFFD);
        tick();
        chk_file("sw_nowrite");
        lw_data = 32'hDEAD_BEEF;
        set(enc_i(12'd8, 5'd1, 3'b010, 5'd5, OP_LD));
        chk("lw_we", 32'(sig_mem_we), 32'd0);
        chk("lw_addr", alu_res, 32'h108);
        tick(); m[5] = 32'hDEAD_BEEF;
        chk("lw_x5", reg_of(5), 32'hDEAD_BEEF);

        set(enc_i(12'd5, 5'd0, 3'd0, 5'd1, OP_I)); tick(); m[1] = 32'd5;
        set(enc_b(13'd8, 5'd1, 5'd2, 3'd4));
        chk("blt_bcond", 32'(sig_fetch_bcond), 32'd1);
        chk("blt_taken", 32'(alu_res[0]), 32'd1);
        tick();
        set(enc_b(13'd8, 5'd1, 5'd2, 3'd6));
        chk("bltu_taken", 32'(alu_res[0]), 32'd0);
        tick();
        set(enc_b(13'd8, 5'd1, 5'd1, 3'd0));
        chk("beq_taken", 32'(alu_res[0]), 32'd1);
        tick();
        chk_file("branch_nowrite");

        pc = 32'h40;
        set(enc_j(21'd16, 5'd1));
        chk("jal_adv", 32'(sig_fetch_advance_by_imm), 32'd1);
        chk("jal_imm", imm, 32'd16);
        tick(); m[1] = 32'h44;
        chk("jal_link", reg_of(1), 32'h44);
        set(enc_i(12'd1, 5'd1, 3'd0, 5'd6, OP_JR));
        chk("jalr_adv", 32'(sig_fetch_advance_gpr), 32'd1);
        chk("jalr_target", alu_res & ~32'd1, 32'h44);
        tick(); m[6] = 32'h44;
        chk("jalr_link", reg_of(6), 32'h44);

        set(32'h0010_0073);
        chk("ebreak", 32'(sig_ebreak), 32'd1);
        chk("ebreak_ctl", {27'd0, sig_mem_we, sig_fetch_advance_gpr,
            sig_fetch_advance_by_imm, sig_fetch_bcond, sig_illegal}, 32'd0);
        tick();
        chk_file("ebreak_nowrite");
        set(32'hFFFF_FFFF);
        chk("illegal", 32'(sig_illegal), 32'd1);
        chk("illegal_ctl", {27'd0, sig_mem_we, sig_fetch_advance_gpr,
            sig_fetch_advance_by_imm, sig_fetch_bcond, sig_ebreak}, 32'd0);
        tick();
        chk_file("illegal_nowrite");
        set(enc_u(20'h12345, 5'd7)); tick(); m[7] = 32'h1234_5000;
        chk("lui_x7", reg_of(7), 32'h1234_5000);

        // Randomized: seed every register with LUI, then mix ALU ops, loads and branches.
        for (int i = 1; i < 32; i++) begin
            a = $urandom;
            set(enc_u(a[19:0], 5'(i))); tick(); m[i] = {a[19:0], 12'b0};
        end
        chk_file("rand_seed");
        for (int it = 0; it < 300; it++) begin
            sel = $urandom_range(0, 24);
            d   = 5'($urandom_range(0, 31));
            s1  = 5'($urandom_range(0, 31));
            s2  = 5'($urandom_range(0, 31));
            a   = m[s1];
            if (sel < 10) begin
                b   = m[s2];
                exp = ref_op(sel, a, b);
                ins = enc_r((sel == 1 || sel == 7) ? 7'h20 : 7'h00, s2, s1, 3'(r_f3[sel]), d);
                set(ins);
                chk("rand_r", alu_res, exp);
                tick();
                if (d != 0) m[d] = exp;
            end else if (sel < 19) begin
                k = sel - 10;
                if (k >= 6) begin
                    im12 = {(k == 8) ? 7'h20 : 7'h00, 5'($urandom_range(0, 31))};
                    b    = {27'd0, im12[4:0]};
                end else begin
                    im12 = 12'($urandom);
                    b    = {{20{im12[11]}}, im12};
                end
                exp = ref_op(i_op[k], a, b);
                set(enc_i(im12, s1, 3'(i_f3[k]), d, OP_I));
                chk("rand_i", alu_res, exp);
                tick();
                if (d != 0) m[d] = exp;
            end else if (sel == 19) begin
                ld = $urandom;
                lw_data = ld;
                im12 = 12'($urandom);
                set(enc_i(im12, s1, 3'b010, d, OP_LD));
                chk("rand_lw_addr", alu_res, a + {{20{im12[11]}}, im12});
                tick();
                if (d != 0) m[d] = ld;
            end else begin
                k = sel - 20;
                if (k > 5) k = 5;
                b = m[s2];
                set(enc_b(13'd4, s2, s1, 3'(b_f3[k])));
                chk("rand_b", {30'd0, sig_fetch_bcond, alu_res[0]},
                    {30'd0, 1'b1, ref_taken(k, a, b)});
                tick();
            end
            chk_file("rand_file");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
